// File: rtl/score_display_ctrl.sv
// Binary score to four-digit BCD converter for a seven-segment scoreboard.
// Uses a fixed 14-step shift-add-3 (double dabble) sequence, so every
// conversion takes the same 15 cycles regardless of the value. Scores above
// 9999 saturate to 9999 and raise overflow. Leading zeros can be blanked
// (nibble 4'hF) so the segment decoders show nothing for them.
// IN_W is expected to lie in 14..16.
module score_display_ctrl #(
  parameter int IN_W     = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [IN_W-1:0] score_in,
  input  logic            load,
  output logic            busy,
  output logic            done,
  output logic [15:0]     digits,
  output logic            overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LATCH   = 2'd2
  } state_t;

  localparam logic [15:0] RESET_DIGITS = BLANK_LZ ? 16'hFFF0 : 16'h0000;
  localparam logic [3:0]  NUM_STEPS    = 4'd14;

  state_t      r_state;
  state_t      w_next;
  logic [13:0] r_sat;
  logic        r_ovf;
  logic [15:0] r_acc;
  logic [3:0]  r_cnt;
  logic        w_over;
  logic [13:0] w_sat;
  logic [15:0] w_adj;
  logic [15:0] w_blanked;

  // Saturate the incoming score; bits above 13 only matter for this test.
  always_comb begin
    w_over = (score_in > IN_W'(9999));
    w_sat  = w_over ? 14'd9999 : score_in[13:0];
  end

  // State register; reset drops back to IDLE, aborting any conversion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: loads are only looked at while idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = CONVERT;
      CONVERT: if (r_cnt == 4'd1) w_next = LATCH;
      LATCH:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction: any BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 4; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking from the thousands digit down; ones always shown.
  always_comb begin
    w_blanked = r_acc;
    if (BLANK_LZ) begin
      if (r_acc[15:12] == 4'd0) begin
        w_blanked[15:12] = 4'hF;
        if (r_acc[11:8] == 4'd0) begin
          w_blanked[11:8] = 4'hF;
          if (r_acc[7:4] == 4'd0) begin
            w_blanked[7:4] = 4'hF;
          end
        end
      end
    end
  end

  // Datapath and registered outputs; outputs only move in LATCH or on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sat    <= '0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      digits   <= RESET_DIGITS;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_sat <= w_sat;
            r_ovf <= w_over;
            r_acc <= '0;
            r_cnt <= NUM_STEPS;
            busy  <= 1'b1;
          end
        end
        CONVERT: begin
          r_acc <= (w_adj << 1) | {15'd0, r_sat[13]};
          r_sat <= {r_sat[12:0], 1'b0};
          r_cnt <= r_cnt - 4'd1;
        end
        LATCH: begin
          digits   <= w_blanked;
          overflow <= r_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed testbench for score_display_ctrl. Two instances share clock,
// reset and load: one with 14-bit input and blanking, one with 16-bit input
// and raw BCD, so saturation of wide inputs and both display modes are seen.
module tb_score_display_ctrl;

  logic        clk;
  logic        resetn;
  logic        load;
  logic [15:0] scoreIn16;
  logic [13:0] scoreIn14;
  logic        busyB, doneB, ovfB;
  logic        busyR, doneR, ovfR;
  logic [15:0] digitsB, digitsR;

  int assertionsEvaluated = 0;
  int failures = 0;
  int doneCount;
  int quietCycles;

  assign scoreIn14 = scoreIn16[13:0];

  score_display_ctrl #(.IN_W(14), .BLANK_LZ(1'b1)) dutBlank (
    .clk(clk), .resetn(resetn), .score_in(scoreIn14), .load(load),
    .busy(busyB), .done(doneB), .digits(digitsB), .overflow(ovfB)
  );

  score_display_ctrl #(.IN_W(16), .BLANK_LZ(1'b0)) dutRaw (
    .clk(clk), .resetn(resetn), .score_in(scoreIn16), .load(load),
    .busy(busyR), .done(doneR), .digits(digitsR), .overflow(ovfR)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One immediate assertion per comparison, counting and reporting failures.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertionsEvaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request a conversion; the accepting edge is E0, both DUTs must go busy.
  task automatic applyStimulus(input logic [15:0] val);
    @(negedge clk);
    scoreIn16 = val;
    load      = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    checkOutput($sformatf("busy after E0 (%0d)", val), {14'd0, busyB, busyR}, 16'h0003);
    checkOutput($sformatf("done low after E0 (%0d)", val), {14'd0, doneB, doneR}, 16'h0000);
  endtask

  // Walk E1..E14 expecting busy with no done, then check the E15 results.
  task automatic runConversion(input string tag, input logic [15:0] expB, input logic expOvfB,
                               input logic [15:0] expR, input logic expOvfR);
    quietCycles = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (busyB && busyR && !doneB && !doneR) quietCycles++;
    end
    checkOutput({tag, " busy E1-E14"}, 16'(quietCycles), 16'd14);
    @(posedge clk);
    #1;
    checkOutput({tag, " done at E15"}, {14'd0, doneB, doneR}, 16'h0003);
    checkOutput({tag, " busy falls at E15"}, {14'd0, busyB, busyR}, 16'h0000);
    checkOutput({tag, " digits blanked"}, digitsB, expB);
    checkOutput({tag, " digits raw"}, digitsR, expR);
    checkOutput({tag, " overflow"}, {14'd0, ovfB, ovfR}, {14'd0, expOvfB, expOvfR});
  endtask

  // Directed sequence of scenarios.
  initial begin
    resetn    = 1'b0;
    load      = 1'b0;
    scoreIn16 = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy/done", {12'd0, busyB, busyR, doneB, doneR}, 16'h0000);
    checkOutput("reset overflow", {14'd0, ovfB, ovfR}, 16'h0000);
    checkOutput("reset digits blanked", digitsB, 16'hFFF0);
    checkOutput("reset digits raw", digitsR, 16'h0000);
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(16'd0);
    runConversion("zero", 16'hFFF0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(16'd1234);
    runConversion("1234", 16'h1234, 1'b0, 16'h1234, 1'b0);
    applyStimulus(16'd10000);
    runConversion("10000", 16'h9999, 1'b1, 16'h9999, 1'b1);
    applyStimulus(16'd42);
    runConversion("42", 16'hFF42, 1'b0, 16'h0042, 1'b0);
    applyStimulus(16'd5);
    runConversion("5", 16'hFFF5, 1'b0, 16'h0005, 1'b0);
    applyStimulus(16'd907);
    runConversion("907", 16'hF907, 1'b0, 16'h0907, 1'b0);
    applyStimulus(16'd9999);
    runConversion("9999", 16'h9999, 1'b0, 16'h9999, 1'b0);
    applyStimulus(16'd1000);
    runConversion("1000", 16'h1000, 1'b0, 16'h1000, 1'b0);
    applyStimulus(16'd10);
    runConversion("10", 16'hFF10, 1'b0, 16'h0010, 1'b0);
    applyStimulus(16'd65535);
    runConversion("65535", 16'h9999, 1'b1, 16'h9999, 1'b1);
    applyStimulus(16'd16384);
    runConversion("16384", 16'hFFF0, 1'b0, 16'h9999, 1'b1);

    // Load of 9000 at E5 must be ignored with no queuing.
    applyStimulus(16'd56);
    doneCount = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 5) begin
        scoreIn16 = 16'd9000;
        load      = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(posedge clk);
      #1;
      if (doneB) doneCount++;
      if (c == 15) begin
        checkOutput("busy-load digits blanked", digitsB, 16'hFF56);
        checkOutput("busy-load digits raw", digitsR, 16'h0056);
      end
    end
    checkOutput("busy-load done pulses", 16'(doneCount), 16'd1);
    checkOutput("busy-load idle after", {14'd0, busyB, busyR}, 16'h0000);

    // Reset at E7 aborts the conversion; first edge after release accepts.
    applyStimulus(16'd777);
    repeat (6) @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("mid-reset busy/done", {12'd0, busyB, busyR, doneB, doneR}, 16'h0000);
    checkOutput("mid-reset digits blanked", digitsB, 16'hFFF0);
    checkOutput("mid-reset digits raw", digitsR, 16'h0000);
    doneCount = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (doneB || doneR) doneCount++;
    end
    checkOutput("mid-reset no done", 16'(doneCount), 16'd0);
    @(negedge clk);
    resetn    = 1'b1;
    scoreIn16 = 16'd777;
    load      = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    checkOutput("first edge after reset accepts", {14'd0, busyB, busyR}, 16'h0003);
    runConversion("777 after reset", 16'hF777, 1'b0, 16'h0777, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("done single cycle", {14'd0, doneB, doneR}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionsEvaluated, failures);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameter IN_W, default 14, sets the binary score input width; the valid range is 14..16.
REQ-002 Parameter BLANK_LZ, default 1, selects leading-zero blanking (1 = blank, 0 = show zeros).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 score_in  input  IN_W  unsigned binary score, sampled only on an accepted load.
REQ-006 load  input  1  conversion request, sampled each rising edge.
REQ-007 busy  output  1  registered; high while a conversion is in progress.
REQ-008 done  output  1  registered; one-cycle pulse when new digits are valid.
REQ-009 digits  output  16  registered BCD nibbles, digit0 (ones) in [3:0] through digit3 (thousands) in [15:12], each nibble driving one seven-segment decoder.
REQ-010 overflow  output  1  registered; high when the last accepted score exceeded 9999.

Function
REQ-011 The FSM SHALL have three states: IDLE, CONVERT, LATCH.
REQ-012 In IDLE with load=1, the block SHALL accept at that edge (E0) and perform all of the following:
- capture sat = min(score_in, 9999);
- capture ovf = (score_in > 9999);
- clear the 16-bit BCD accumulator;
- load the bit counter with 14;
- enter CONVERT.
REQ-013 In CONVERT, each edge SHALL perform one shift-add-3 step and then decrement the counter; 14 steps occupy edges E1..E14.
- Step part 1: each accumulator nibble >= 5 gets +3.
- Step part 2: shift {accumulator, sat[13:0]} left by one.
REQ-014 After the 14th step, the FSM SHALL enter LATCH; LATCH SHALL last exactly one cycle and then return to IDLE.
REQ-015 At edge E15 (LATCH), the block SHALL update all of the following together, and no outputs change at any other edge except reset:
- digits <= blanked accumulator;
- overflow <= ovf;
- done <= 1.
REQ-016 done SHALL be high for exactly one cycle, following E15, and low otherwise.
REQ-017 busy SHALL be 1 from E0 until E15; busy falls at the same edge at which done rises.
REQ-018 A load while busy=1 (CONVERT or LATCH) SHALL be ignored, with no queuing; the in-flight conversion is unaffected.
REQ-019 A load asserted in the cycle when done=1 SHALL be accepted, because the FSM is in IDLE.
REQ-020 Blanking with BLANK_LZ=1: starting from digit3 downward, each nibble that is 0 while all more-significant nibbles are also blanked SHALL be replaced by 4'hF; digit0 is never blanked.
REQ-021 With BLANK_LZ=0, digits SHALL equal the raw BCD value.
REQ-022 Every digits nibble SHALL be 0..9 or 4'hF; no other codes are permitted.
REQ-023 Bits of score_in above bit 13 SHALL only affect saturation and ovf; the conversion always runs 14 steps.
REQ-024 Input-to-output latency SHALL be 15 cycles from accepting edge E0 to digits valid, for every input value, with no data-dependent timing.

Reset
REQ-025 While resetn=0, the block SHALL hold all of the following:
- FSM = IDLE;
- busy = 0;
- done = 0;
- overflow = 0;
- accumulator and counter cleared;
- digits = 16'hFFF0 if BLANK_LZ=1, else 16'h0000.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion immediately; done SHALL NOT pulse for it, and the next load after release SHALL start a fresh conversion.
REQ-027 The first edge after resetn rises SHALL accept a load if load=1.

Verification
REQ-028 Scenario, zero score: BLANK_LZ=1, load with score_in=0 -> done at E15, digits=16'hFFF0, overflow=0.
REQ-029 Scenario, full value: load with score_in=1234 -> busy high for 15 cycles, done is a single pulse after E15, digits=16'h1234.
REQ-030 Scenario, saturation: load with score_in=10000 -> digits=16'h9999, overflow=1; a following load of 42 -> digits=16'hFF42, overflow=0.
REQ-031 Scenario, blanking off: BLANK_LZ=0, load with score_in=5 -> digits=16'h0005; score_in=907 -> 16'h0907.
REQ-032 Scenario, load while busy: load 56, then load 9000 at E5 -> the 9000 request is ignored, digits=16'hFF56, exactly one done pulse.
REQ-033 Scenario, reset mid-operation: load 777, assert resetn=0 at E7 -> digits=16'hFFF0, no done pulse; after release, load 777 -> digits=16'hF777.
